// File: rtl/state_sharer_pkg.sv
// Shared definitions for the state_sharer masking front-end.
// Holds the block width, FSM state encoding and the mask-word count helper.
// Imported by the top and by the share_pack sub-module.
package state_sharer_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Number of RW-bit random words needed to mask one block with d shares.
  function automatic int nw(input int d, input int rw);
    return (BLOCK_W * (d - 1)) / rw;
  endfunction

  // Word counter width: clog2(n+1), never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/state_sharer_share_pack.sv
// Purpose: map an unmasked block plus its mask vector onto the bit-interleaved d-share layout.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports:
//   data  - 128-bit unmasked block
//   mask  - mask vector; bit (j-1)*128+b is share j of bit b
//   sh    - shared block; share j of bit b at sh[D*b+j], share 0 = data ^ all masks
module state_sharer_share_pack
  import state_sharer_pkg::*;
#(
  parameter int D      = 2,
  parameter int MASK_W = 128
) (
  input  logic [BLOCK_W-1:0]   data,
  input  logic [MASK_W-1:0]    mask,
  output logic [BLOCK_W*D-1:0] sh
);

  always_comb begin
    logic acc;
    sh  = '0;
    acc = 1'b0;
    for (int b = 0; b < BLOCK_W; b++) begin
      acc = data[b];
      for (int j = 1; j < D; j++) begin
        sh[D*b+j] = mask[(j-1)*BLOCK_W+b];
        acc       = acc ^ mask[(j-1)*BLOCK_W+b];
      end
      sh[D*b] = acc;
    end
  end

endmodule

// File: rtl/state_sharer.sv
// Purpose: latch a 128-bit block, gather NW random words, emit a registered d-share Boolean sharing.
// Latency: accept at edge T, out_valid in cycle T+NW+1 with rnd_valid held high (T+1 when D=1).
// Backpressure: in_ready only in IDLE, rnd_ready only in GATHER, DONE holds until out_ready.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     - unmasked block input
//   rnd_data/rnd_valid/rnd_ready  - fresh randomness, RW bits per word
//   sh_out/out_valid/out_ready    - shared block, layout sh_out[D*b+j]
// Optional: define STATE_SHARER_ZEROIZE_EN to clear data/mask/share registers on the output
// handshake and force sh_out to 0 while out_valid is low.
module state_sharer
  import state_sharer_pkg::*;
#(
  parameter int D  = 2,
  parameter int RW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BLOCK_W-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RW-1:0]        rnd_data,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [BLOCK_W*D-1:0] sh_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int NW     = nw(D, RW);
  localparam int CW     = cnt_w(NW);
  localparam int SH_W   = BLOCK_W * D;
  // Kept at least RW wide so the word-slot slices stay in range when D=1.
  localparam int MASK_W = (D > 1) ? BLOCK_W * (D - 1) : RW;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BLOCK_W-1:0]  data_q, data_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [SH_W-1:0]     sh_pack;
  logic                last_word;
  logic                load_sh;

  assign last_word = (cnt_q == CW'(NW - 1));

  // Packing works on the next-cycle data/mask so the final word lands in the
  // share register on the same edge that enters DONE.
  state_sharer_share_pack #(
    .D      (D),
    .MASK_W (MASK_W)
  ) u_share_pack (
    .data (data_d),
    .mask (mask_d),
    .sh   (sh_pack)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = (NW > 0) ? GATHER : DONE;
      end
      GATHER: begin
        if (rnd_valid && last_word) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    data_d  = data_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    load_sh = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          load_sh = (NW == 0);
        end
      end
      GATHER: begin
        if (rnd_valid) begin
          for (int k = 0; k < NW; k++) begin
            if (cnt_q == CW'(k)) mask_d[RW*k +: RW] = rnd_data;
          end
          cnt_d   = cnt_q + CW'(1);
          load_sh = last_word;
        end
      end
      DONE: begin
`ifdef STATE_SHARER_ZEROIZE_EN
        if (out_ready) begin
          data_d = '0;
          mask_d = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    sh_d = sh_q;
    if (load_sh) sh_d = sh_pack;
`ifdef STATE_SHARER_ZEROIZE_EN
    if (state_q == DONE && out_ready) sh_d = '0;
`endif
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
      mask_q <= '0;
      sh_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      mask_q <= mask_d;
      sh_q   <= sh_d;
    end
  end

  // Outputs: decoded from registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    rnd_ready = (state_q == GATHER);
    out_valid = (state_q == DONE);
`ifdef STATE_SHARER_ZEROIZE_EN
    sh_out    = out_valid ? sh_q : '0;
`else
    sh_out    = sh_q;
`endif
  end

endmodule

// File: tb/tb_state_sharer.sv
// Purpose: self-checking bench for state_sharer (D=2/RW=32 and D=1 instances).
// Latency: expects out_valid at cycle T+5 (continuous), T+9 (alternate rnd_valid), T+1 (D=1).
// Backpressure: exercises out_ready hold, mid-gather reset and the optional zeroize behaviour.
module tb_state_sharer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges so far; cycle n is the one that ends at edge n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] in_data2, in_data1;
  logic         in_valid2, in_valid1, in_ready2, in_ready1;
  logic [31:0]  rnd_data2, rnd_data1;
  logic         rnd_valid2, rnd_valid1, rnd_ready2, rnd_ready1;
  logic [255:0] sh_out2;
  logic [127:0] sh_out1;
  logic         out_valid2, out_valid1, out_ready2, out_ready1;

  state_sharer #(.D(2), .RW(32)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .rnd_data(rnd_data2), .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2),
    .sh_out(sh_out2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  state_sharer #(.D(1), .RW(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .rnd_data(rnd_data1), .rnd_valid(rnd_valid1), .rnd_ready(rnd_ready1),
    .sh_out(sh_out1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  typedef struct {
    logic [255:0] sh;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t sb2[$];
  exp_t sb1[$];
  exp_t e2, e1;

  localparam logic [127:0] D_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] W_A = {32'hcafef00d, 32'h89abcdef, 32'h01234567, 32'hdeadbeef};
  localparam logic [127:0] W_B = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] D_C = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] W_C = {32'h0f0f0f0f, 32'h33333333, 32'h55555555, 32'haaaaaaaa};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference layout for d=2: share 1 of bit b is mask bit b, share 0 is data^mask.
  function automatic logic [255:0] share2(input logic [127:0] data, input logic [127:0] m);
    logic [255:0] r;
    for (int b = 0; b < 128; b++) begin
      r[2*b+1] = m[b];
      r[2*b]   = data[b] ^ m[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] recomb2(input logic [255:0] s);
    logic [127:0] r;
    for (int b = 0; b < 128; b++) r[b] = s[2*b] ^ s[2*b+1];
    return r;
  endfunction

  function automatic logic [127:0] mask2(input logic [255:0] s);
    logic [127:0] r;
    for (int b = 0; b < 128; b++) r[b] = s[2*b+1];
    return r;
  endfunction

  // ---------------- monitors ----------------
  logic ov2_q = 1'b0;
  logic ov1_q = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ov2_q = 1'b0;
    end else begin
      chk("rdy_excl2", {255'd0, in_ready2 & rnd_ready2}, 256'd0);
      chk("rnd_rdy_not_done2", {255'd0, rnd_ready2 & out_valid2}, 256'd0);
      if (out_valid2 && !ov2_q) begin
        if (sb2.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb2_unexpected: got out_valid at cycle %0d want none", cyc + 1);
        end else begin
          e2 = sb2.pop_front();
          chk("sh_out2", sh_out2, e2.sh);
          chk("latency2", 256'(cyc + 1), 256'(e2.due));
          chk("recomb2", {128'd0, recomb2(sh_out2)}, {128'd0, e2.data});
          chk("mask_bits2", {128'd0, mask2(sh_out2)}, {128'd0, mask2(e2.sh)});
        end
      end
      ov2_q = out_valid2;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ov1_q = 1'b0;
    end else begin
      chk("rnd_rdy1_never", {255'd0, rnd_ready1}, 256'd0);
      if (out_valid1 && !ov1_q) begin
        if (sb1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb1_unexpected: got out_valid at cycle %0d want none", cyc + 1);
        end else begin
          e1 = sb1.pop_front();
          chk("sh_out1", {128'd0, sh_out1}, e1.sh);
          chk("latency1", 256'(cyc + 1), 256'(e1.due));
        end
      end
      ov1_q = out_valid1;
    end
  end

  // ---------------- drivers ----------------
  int t_acc;

  task automatic start2(input logic [127:0] data);
    @(negedge clk);
    in_data2  = data;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    t_acc     = cyc;
  endtask

  // Feeds n words; alt=1 holds rnd_valid low on every other cycle starting low.
  task automatic feed2(input logic [127:0] words, input int n, input bit alt);
    int  k = 0;
    int  guard = 0;
    bit  v, hs;
    while (k < n && guard < 40) begin
      v = alt ? (guard % 2 == 1) : 1'b1;
      rnd_valid2 = v;
      rnd_data2  = words[32*k +: 32];
      @(negedge clk);
      hs = v && rnd_ready2;
      @(posedge clk);
      #1;
      if (hs) k++;
      guard++;
    end
    rnd_valid2 = 1'b0;
    chk("feed2_done", 256'(k), 256'(n));
  endtask

  task automatic wait_idle2();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready2 && !out_valid2) ok = 1'b1;
    end
    chk("idle2_timeout", {255'd0, ok}, 256'd1);
  endtask

  task automatic send2(input logic [127:0] data, input logic [127:0] words, input bit alt);
    exp_t e;
    start2(data);
    feed2(words, 4, alt);
    e.sh   = share2(data, words);
    e.data = data;
    e.due  = t_acc + (alt ? 9 : 5);
    sb2.push_back(e);
    wait_idle2();
  endtask

  initial begin
    exp_t e;
    bit   ok;
    in_data2 = '0; in_valid2 = 0; rnd_data2 = '0; rnd_valid2 = 0; out_ready2 = 1;
    in_data1 = '0; in_valid1 = 0; rnd_data1 = '0; rnd_valid1 = 0; out_ready1 = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_in_ready2",  {255'd0, in_ready2},  256'd1);
    chk("rst_rnd_ready2", {255'd0, rnd_ready2}, 256'd0);
    chk("rst_out_valid2", {255'd0, out_valid2}, 256'd0);
    chk("rst_sh_out2",    sh_out2,              256'd0);
    chk("rst_in_ready1",  {255'd0, in_ready1},  256'd1);
    chk("rst_out_valid1", {255'd0, out_valid1}, 256'd0);
    rst_n = 1'b1;

    // Continuous randomness: out_valid at T+5
    send2(D_A, W_A, 1'b0);

    // Alternate rnd_valid: out_valid at T+9, same sharing
    send2(D_A, W_A, 1'b1);

    // Hold in DONE for 10 cycles with out_ready low
    out_ready2 = 1'b0;
    start2(D_A);
    feed2(W_A, 4, 1'b0);
    e.sh = share2(D_A, W_A); e.data = D_A; e.due = t_acc + 5;
    sb2.push_back(e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid2",   {255'd0, out_valid2}, 256'd1);
      chk("hold_in_rdy2",  {255'd0, in_ready2},  256'd0);
      chk("hold_sh_out2",  sh_out2,              share2(D_A, W_A));
    end
    // Hand-derived interleaved bytes: byte0 data ff mask ef, byte15 data 00 mask ca
    chk("byte0_hand",  {240'd0, sh_out2[15:0]},    {240'd0, 16'ha9aa});
    chk("byte15_hand", {240'd0, sh_out2[255:240]}, {240'd0, 16'hf0cc});
    out_ready2 = 1'b1;
    @(negedge clk);
    chk("release_in_rdy2", {255'd0, in_ready2},  256'd1);
    chk("release_valid2",  {255'd0, out_valid2}, 256'd0);
`ifdef STATE_SHARER_ZEROIZE_EN
    chk("zeroize_sh_out2", sh_out2, 256'd0);
`else
    chk("retain_sh_out2",  sh_out2, share2(D_A, W_A));
`endif

    // Reset mid-GATHER after two words: async clear, no output
    start2(D_C);
    feed2(W_B, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready2",  {255'd0, in_ready2},  256'd1);
    chk("arst_rnd_ready2", {255'd0, rnd_ready2}, 256'd0);
    chk("arst_out_valid2", {255'd0, out_valid2}, 256'd0);
    chk("arst_sh_out2",    sh_out2,              256'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send2(D_C, W_C, 1'b0);

    // D=1: out_valid at T+1, sh_out == in_data
    @(negedge clk);
    in_data1  = D_C;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    e.sh = {128'd0, D_C}; e.data = D_C; e.due = cyc + 1;
    sb1.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready1 && !out_valid1) ok = 1'b1;
    end
    chk("idle1_timeout", {255'd0, ok}, 256'd1);

    repeat (2) @(negedge clk);
    chk("sb2_drained", 256'(sb2.size()), 256'd0);
    chk("sb1_drained", 256'(sb1.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
